// File: rtl/spi_frame_controller_if.sv
// Byte-stream, RX FIFO and TX source signals of spi_frame_controller.
// The controller uses the slave modport; its driver uses master.
interface spi_frame_controller_if;
    logic       spi_cycle_done;
    logic [7:0] spi_byte_in;
    logic [7:0] spi_byte_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] state;
    logic       frame_done;
    logic       frame_error;

    modport master (
        output spi_cycle_done, spi_byte_in, rx_ready,
        output tx_data, tx_valid,
        input  spi_byte_out, rx_data, rx_valid, tx_ready,
        input  state, frame_done, frame_error
    );

    modport slave (
        input  spi_cycle_done, spi_byte_in, rx_ready,
        input  tx_data, tx_valid,
        output spi_byte_out, rx_data, rx_valid, tx_ready,
        output state, frame_done, frame_error
    );
endinterface

// File: rtl/spi_frame_controller.sv
// SPI frame decoder: command, big-endian length, then ECHO/WRITE/READ data.
// Optional inter-byte abort timer enabled by macro SPI_FRAME_TIMEOUT_EN.
module spi_frame_controller #(
    parameter int unsigned SIZE_BYTES     = 3,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic clk,
    input logic rst,
    spi_frame_controller_if.slave bus
);
    localparam int LW = 8 * SIZE_BYTES;
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIZE  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ECHO  = 3'd4
    } state_e;

    state_e          state_q;
    state_e          mode_q;
    logic [LW-1:0]   length_q;
    logic [2:0]      bcnt_q;
    logic [7:0]      byte_out_q;
    logic            tx_ready_q;
    logic            done_q;
    logic            err_q;
    logic            ovf_q;
    logic            unf_q;

    logic [7:0]      mem [RX_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            full;
    logic            pop;
    logic            wr_byte;
    logic            rd_byte;
    logic            push;
    logic            drop;
    logic            byte_err;
    logic            state_ok;
    logic [LW-1:0]   len_shift;

`ifdef SPI_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   to_q;
`endif

    assign full     = count_q == CW'(RX_DEPTH);
    assign pop      = (count_q != '0) && bus.rx_ready;
    assign wr_byte  = bus.spi_cycle_done && state_q == WRITE;
    assign rd_byte  = bus.spi_cycle_done && state_q == READ;
    // A pop on the same edge frees the slot the push needs.
    assign push     = wr_byte && (!full || pop);
    assign drop     = wr_byte && full && !pop;
    assign byte_err = drop || (rd_byte && !bus.tx_valid);
    assign len_shift = (length_q << 8) | LW'(bus.spi_byte_in);
    assign state_ok = state_q inside {IDLE, SIZE, WRITE, READ, ECHO};

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.spi_byte_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= IDLE;
            length_q   <= '0;
            bcnt_q     <= '0;
            byte_out_q <= 8'h00;
            tx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef SPI_FRAME_TIMEOUT_EN
            to_q       <= '0;
`endif
        end else begin
            tx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SPI_FRAME_TIMEOUT_EN
            if (bus.spi_cycle_done || state_q == IDLE)
                to_q <= '0;
            else
                to_q <= to_q + 1'b1;
`endif
            if (!state_ok) begin
                state_q <= IDLE;
            end else if (bus.spi_cycle_done) begin
                case (state_q)
                    IDLE: begin
                        byte_out_q <= 8'h00;
                        ovf_q      <= 1'b0;
                        unf_q      <= 1'b0;
                        length_q   <= '0;
                        bcnt_q     <= '0;
                        case (bus.spi_byte_in)
                            8'h01: begin
                                mode_q  <= ECHO;
                                state_q <= SIZE;
                            end
                            8'h02: begin
                                mode_q  <= WRITE;
                                state_q <= SIZE;
                            end
                            8'h03: begin
                                mode_q  <= READ;
                                state_q <= SIZE;
                            end
                            8'h00:   ;
                            default: err_q <= 1'b1;
                        endcase
                    end
                    SIZE: begin
                        length_q <= len_shift;
                        bcnt_q   <= bcnt_q + 1'b1;
                        if (bcnt_q == 3'(SIZE_BYTES - 1)) begin
                            if (len_shift == '0) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= mode_q;
                            end
                        end
                    end
                    ECHO, WRITE, READ: begin
                        if (state_q == ECHO) begin
                            byte_out_q <= bus.spi_byte_in;
                        end else if (state_q == WRITE) begin
                            byte_out_q <= 8'h00;
                            if (drop) ovf_q <= 1'b1;
                        end else if (bus.tx_valid) begin
                            byte_out_q <= bus.tx_data;
                            tx_ready_q <= 1'b1;
                        end else begin
                            byte_out_q <= 8'h00;
                            unf_q      <= 1'b1;
                        end
                        length_q <= length_q - 1'b1;
                        if (length_q == LW'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            err_q   <= ovf_q | unf_q | byte_err;
                            ovf_q   <= 1'b0;
                            unf_q   <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
`ifdef SPI_FRAME_TIMEOUT_EN
            else if (state_q != IDLE &&
                     to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q    <= IDLE;
                byte_out_q <= 8'h00;
                err_q      <= 1'b1;
                ovf_q      <= 1'b0;
                unf_q      <= 1'b0;
            end
`endif
        end
    end

    assign bus.spi_byte_out = byte_out_q;
    assign bus.rx_data      = mem[rd_ptr_q];
    assign bus.rx_valid     = count_q != '0;
    assign bus.tx_ready     = tx_ready_q;
    assign bus.state        = state_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_error  = err_q;
endmodule

// File: tb/tb_spi_frame_controller.sv
// Scoreboard bench for spi_frame_controller: per-byte response queue
// plus an RX data queue, checked by an independent monitor process.
module tb_spi_frame_controller;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic cd = 1'b0;
    logic [7:0] bin = 8'h00;
    logic rx_rdy = 1'b0;
    logic [7:0] txd = 8'h00;
    logic txv = 1'b0;

    always #5 clk = ~clk;

    spi_frame_controller_if if0 ();
    spi_frame_controller_if if1 ();

    assign if0.spi_cycle_done = cd & ~sel;
    assign if1.spi_cycle_done = cd & sel;
    assign if0.spi_byte_in = bin;
    assign if1.spi_byte_in = bin;
    assign if0.rx_ready = rx_rdy & ~sel;
    assign if1.rx_ready = rx_rdy & sel;
    assign if0.tx_data = txd;
    assign if1.tx_data = txd;
    assign if0.tx_valid = txv & ~sel;
    assign if1.tx_valid = txv & sel;

    spi_frame_controller #(
        .SIZE_BYTES(3), .RX_DEPTH(16), .TIMEOUT_CYCLES(TO)
    ) d0 (.clk(clk), .rst(rst), .bus(if0));

    spi_frame_controller #(
        .SIZE_BYTES(3), .RX_DEPTH(2), .TIMEOUT_CYCLES(TO)
    ) d1 (.clk(clk), .rst(rst), .bus(if1));

    logic [7:0] m_bo, m_rxd;
    logic [2:0] m_st;
    logic m_rxv, m_txr, m_done, m_err;
    assign m_bo   = sel ? if1.spi_byte_out : if0.spi_byte_out;
    assign m_rxd  = sel ? if1.rx_data : if0.rx_data;
    assign m_rxv  = sel ? if1.rx_valid : if0.rx_valid;
    assign m_txr  = sel ? if1.tx_ready : if0.tx_ready;
    assign m_st   = sel ? if1.state : if0.state;
    assign m_done = sel ? if1.frame_done : if0.frame_done;
    assign m_err  = sel ? if1.frame_error : if0.frame_error;

    typedef struct packed {
        logic [7:0] bo;
        logic [2:0] st;
        logic d;
        logic e;
        logic t;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] rx_q[$];
    int checks = 0;
    int fails = 0;
    bit to_armed = 0;
    bit to_seen = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: samples inputs mid-cycle, checks outputs #1 after the edge.
    initial begin
        bit fired, p_pop, p_rst;
        logic [7:0] p_data;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            fired  = cd;
            p_rst  = rst;
            p_pop  = m_rxv && rx_rdy;
            p_data = m_rxd;
            @(posedge clk);
            #1;
            if (p_rst) begin
            end else if (fired) begin
                if (exp_q.size() == 0) begin
                    chk("byte_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_resp",
                        {18'd0, m_bo, m_st, m_done, m_err, m_txr},
                        {18'd0, e});
                end
            end else begin
                if (m_err && to_armed) to_seen = 1;
                chk("no_stray_pulse",
                    {m_done, m_err && !to_armed, m_txr}, 0);
            end
            if (p_pop && !p_rst) begin
                if (rx_q.size() == 0)
                    chk("rx_unexpected_pop", 1, 0);
                else
                    chk("rx_data", p_data, rx_q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the next negedge.
    task automatic send(input logic [7:0] b, input logic [7:0] bo,
                        input logic [2:0] st, input logic d,
                        input logic e, input logic t);
        exp_q.push_back({bo, st, d, e, t});
        cd  = 1'b1;
        bin = b;
        @(negedge clk);
        cd  = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [7:0] len,
                       input logic [2:0] mode);
        send(cmd, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
        send(len, 8'h00, mode, 0, 0, 0);
    endtask

    task automatic drain();
        rx_rdy = 1'b1;
        repeat (5) @(negedge clk);
        rx_rdy = 1'b0;
        chk("rx_empty_after_drain", m_rxv, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", m_st, 0);
        chk("rst_byte_out", m_bo, 0);
        chk("rst_rx_valid", if0.rx_valid | if1.rx_valid, 0);
        chk("rst_pulses", {m_done, m_err, m_txr}, 0);

        // ECHO of three bytes
        hdr(8'h01, 8'h03, 3'd4);
        send(8'hAA, 8'hAA, 3'd4, 0, 0, 0);
        send(8'hBB, 8'hBB, 3'd4, 0, 0, 0);
        send(8'hCC, 8'hCC, 3'd0, 1, 0, 0);

        // WRITE two bytes, pop afterwards
        hdr(8'h02, 8'h02, 3'd2);
        rx_q.push_back(8'h11);
        send(8'h11, 8'h00, 3'd2, 0, 0, 0);
        rx_q.push_back(8'h22);
        send(8'h22, 8'h00, 3'd0, 1, 0, 0);
        chk("rx_valid_after_write", m_rxv, 1);
        drain();

        // READ with one missing payload byte
        hdr(8'h03, 8'h02, 3'd3);
        txd = 8'h5A;
        txv = 1'b1;
        send(8'h01, 8'h5A, 3'd3, 0, 0, 1);
        txv = 1'b0;
        send(8'h02, 8'h00, 3'd0, 1, 1, 0);

        // Bad command, null byte, zero-length frame
        send(8'h7F, 8'h00, 3'd0, 0, 1, 0);
        send(8'h00, 8'h00, 3'd0, 0, 0, 0);
        send(8'h02, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd0, 1, 0, 0);

        // Reset in the middle of a WRITE
        hdr(8'h02, 8'h05, 3'd2);
        send(8'h11, 8'h00, 3'd2, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", m_st, 0);
        chk("midrst_rx_valid", m_rxv, 0);

        // Depth-2 FIFO: overflow, then push alongside a pop
        sel = 1'b1;
        hdr(8'h02, 8'h03, 3'd2);
        rx_q.push_back(8'h11);
        send(8'h11, 8'h00, 3'd2, 0, 0, 0);
        rx_q.push_back(8'h22);
        send(8'h22, 8'h00, 3'd2, 0, 0, 0);
        send(8'h33, 8'h00, 3'd0, 1, 1, 0);
        drain();
        hdr(8'h02, 8'h03, 3'd2);
        rx_q.push_back(8'h44);
        send(8'h44, 8'h00, 3'd2, 0, 0, 0);
        rx_q.push_back(8'h55);
        send(8'h55, 8'h00, 3'd2, 0, 0, 0);
        rx_q.push_back(8'h66);
        rx_rdy = 1'b1;
        send(8'h66, 8'h00, 3'd0, 1, 0, 0);
        drain();
        sel = 1'b0;

        // Stalled frame: abort with the timer, persist without it
        send(8'h01, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
`ifdef SPI_FRAME_TIMEOUT_EN
        to_armed = 1;
        repeat (TO + 10) @(negedge clk);
        to_armed = 0;
        chk("timeout_error", to_seen, 1);
        chk("timeout_state", m_st, 0);
`else
        repeat (TO + 10) @(negedge clk);
        chk("no_timeout_state", m_st, 1);
        send(8'h00, 8'h00, 3'd1, 0, 0, 0);
        send(8'h00, 8'h00, 3'd0, 1, 0, 0);
`endif

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && rx_q.size() == 0) break;
            @(negedge clk);
        end
        chk("exp_q_left", exp_q.size(), 0);
        chk("rx_q_left", rx_q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
